// File: rtl/regwr_arb.sv
// Register-file write-port arbiter: pipeline write-back vs multi-cycle unit, with halt drain.
// Optional REGWR_ZERO_REG_EN: transfers to register 0 handshake but never assert wr_en.
module regwr_arb #(
   parameter int WIDTH        = 32,
   parameter int REG_ADDR_LEN = 5,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_valid,
   output logic                    wb_ready,
   input  logic [REG_ADDR_LEN-1:0] wb_addr,
   input  logic [WIDTH-1:0]        wb_data,
   input  logic [1:0]              wb_mode,
   input  logic                    mdu_valid,
   output logic                    mdu_ready,
   input  logic [REG_ADDR_LEN-1:0] mdu_addr,
   input  logic [WIDTH-1:0]        mdu_data,
   input  logic [1:0]              mdu_mode,
   input  logic                    mdu_busy,
   input  logic                    halt_req,
   output logic                    halted,
   output logic [REG_ADDR_LEN-1:0] Addr,
   output logic [WIDTH-1:0]        Data,
   output logic                    wr_en,
   output logic [1:0]              w_mode
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t                  state_q, state_d;
   logic [2:0]              starve_q, starve_d;
   logic [REG_ADDR_LEN-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]        data_q, data_d;
   logic [1:0]              mode_q, mode_d;
   logic                    wr_q, wr_d;
   logic                    mdu_first;
   logic                    xfer;

   assign mdu_first = mdu_valid && (starve_q == LIMIT);
   assign xfer      = wb_ready || mdu_ready;

   always_comb begin
      wb_ready  = 1'b0;
      mdu_ready = 1'b0;
      state_d   = state_q;
      if (!rst) begin
         case (state_q)
            RUN: begin
               if (mdu_first) begin
                  mdu_ready = 1'b1;
               end else if (wb_valid) begin
                  wb_ready = 1'b1;
               end else begin
                  mdu_ready = mdu_valid;
               end
               if (halt_req) state_d = DRAIN;
            end
            DRAIN: begin
               mdu_ready = mdu_valid;
               if (!mdu_valid && !mdu_busy) state_d = HALTED;
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
         endcase
      end
   end

   // Starvation counter saturates so MDU keeps priority until it is served.
   always_comb begin
      starve_d = starve_q;
      if (mdu_ready) begin
         starve_d = 3'd0;
      end else if (mdu_valid && (starve_q < LIMIT)) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      mode_d = mode_q;
      if (mdu_ready) begin
         addr_d = mdu_addr;
         data_d = mdu_data;
         mode_d = mdu_mode;
      end else if (wb_ready) begin
         addr_d = wb_addr;
         data_d = wb_data;
         mode_d = wb_mode;
      end
`ifdef REGWR_ZERO_REG_EN
      wr_d = xfer && (addr_d != '0);
`else
      wr_d = xfer;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         starve_q <= 3'd0;
         addr_q   <= '0;
         data_q   <= '0;
         mode_q   <= 2'd0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         mode_q   <= mode_d;
         wr_q     <= wr_d;
      end
   end

   assign halted = (state_q == HALTED);
   assign Addr   = addr_q;
   assign Data   = data_q;
   assign w_mode = mode_q;
   assign wr_en  = wr_q;

endmodule

// File: tb/tb_regwr_arb.sv
// Bench for regwr_arb: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_regwr_arb;

   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0, mdu_valid = 1'b0;
   logic        wb_ready, mdu_ready;
   logic [4:0]  wb_addr = '0, mdu_addr = '0;
   logic [31:0] wb_data = '0, mdu_data = '0;
   logic [1:0]  wb_mode = '0, mdu_mode = '0;
   logic        mdu_busy = 1'b0, halt_req = 1'b0;
   logic        halted, wr_en;
   logic [4:0]  Addr;
   logic [31:0] Data;
   logic [1:0]  w_mode;

   int n_pass  = 0;
   int n_total = 0;

   regwr_arb dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data), .wb_mode(wb_mode),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_mode(mdu_mode),
      .mdu_busy(mdu_busy), .halt_req(halt_req), .halted(halted),
      .Addr(Addr), .Data(Data), .wr_en(wr_en), .w_mode(w_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: phase 0 running, 1 draining, 2 halted.
   int          m_phase = 0;
   int          m_starve = 0;
   bit          m_ok = 0;
   bit          e_wr = 0;
   logic [4:0]  e_addr = '0;
   logic [31:0] e_data = '0;
   logic [1:0]  e_mode = '0;

   always @(negedge clk) begin
      bit gw, gm, zero;
      gw = 0;
      gm = 0;
      if (!rst) begin
         if (m_phase == 0) begin
            if (mdu_valid && m_starve == LIM) gm = 1;
            else if (wb_valid) gw = 1;
            else if (mdu_valid) gm = 1;
         end else if (m_phase == 1) begin
            gm = mdu_valid;
         end
      end
      if (m_ok) begin
         chk("wb_ready", 32'(wb_ready), 32'(gw));
         chk("mdu_ready", 32'(mdu_ready), 32'(gm));
         chk("halted", 32'(halted), 32'(m_phase == 2));
         chk("wr_en", 32'(wr_en), 32'(e_wr));
         chk("Addr", 32'(Addr), 32'(e_addr));
         chk("Data", Data, e_data);
         chk("w_mode", 32'(w_mode), 32'(e_mode));
      end
      if (rst) begin
         m_ok = 1;
         m_phase = 0;
         m_starve = 0;
         e_wr = 0;
         e_addr = '0;
         e_data = '0;
         e_mode = '0;
      end else begin
         if (gm) begin
            e_addr = mdu_addr;
            e_data = mdu_data;
            e_mode = mdu_mode;
         end else if (gw) begin
            e_addr = wb_addr;
            e_data = wb_data;
            e_mode = wb_mode;
         end
`ifdef REGWR_ZERO_REG_EN
         zero = (e_addr == 5'd0);
`else
         zero = 0;
`endif
         e_wr = (gw || gm) && !zero;
         if (gm) m_starve = 0;
         else if (mdu_valid && m_starve < LIM) m_starve++;
         if (m_phase == 0 && halt_req) m_phase = 1;
         else if (m_phase == 1 && !mdu_valid && !mdu_busy) m_phase = 2;
      end
   end

   initial begin
      bit wb_hold, mdu_hold;
      // reset state
      cyc();
      cyc();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_Addr", 32'(Addr), 32'd0);
      chk("rst_Data", Data, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      rst = 0;
      cyc();

      // single write-back
      wb_valid = 1; wb_addr = 5; wb_data = 32'h1234; wb_mode = 0;
      #1 chk("wb_only_ready", 32'(wb_ready), 32'd1);
      cyc();
      wb_valid = 0;
      chk("wb_only_wr", 32'(wr_en), 32'd1);
      chk("wb_only_addr", 32'(Addr), 32'd5);
      chk("wb_only_data", Data, 32'h1234);
      cyc();
      chk("wb_only_idle", 32'(wr_en), 32'd0);

      // contention: MDU wins every fourth cycle
      wb_valid = 1; wb_addr = 1; wb_data = 32'h11; wb_mode = 1;
      mdu_valid = 1; mdu_addr = 2; mdu_data = 32'h22; mdu_mode = 2;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("cont_mdu_ready", 32'(mdu_ready), 32'(k % 4 == 3));
         chk("cont_wb_ready", 32'(wb_ready), 32'(k % 4 != 3));
         cyc();
         chk("cont_addr", 32'(Addr), (k % 4 == 3) ? 32'd2 : 32'd1);
      end
      wb_valid = 0; mdu_valid = 0;
      cyc();

      // register 0
      wb_valid = 1; wb_addr = 0; wb_data = 32'hFFFF; wb_mode = 0;
      #1 chk("zero_ready", 32'(wb_ready), 32'd1);
      cyc();
      wb_valid = 0;
`ifdef REGWR_ZERO_REG_EN
      chk("zero_wr", 32'(wr_en), 32'd0);
`else
      chk("zero_wr", 32'(wr_en), 32'd1);
      chk("zero_addr", 32'(Addr), 32'd0);
`endif
      cyc();

      // halt with MDU op in flight
      halt_req = 1; mdu_busy = 1;
      wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
      #1 chk("halt_wb_ready", 32'(wb_ready), 32'd1);
      cyc();
      halt_req = 0; wb_addr = 10;
      #1 chk("drain_wb_blocked", 32'(wb_ready), 32'd0);
      chk("drain_last_wb", 32'(Addr), 32'd9);
      cyc(); cyc(); cyc();
      mdu_valid = 1; mdu_busy = 0; mdu_addr = 7; mdu_data = 32'hCAFE;
      #1 chk("drain_mdu_ready", 32'(mdu_ready), 32'd1);
      cyc();
      mdu_valid = 0;
      chk("drain_wr", 32'(wr_en), 32'd1);
      chk("drain_addr", 32'(Addr), 32'd7);
      chk("drain_data", Data, 32'hCAFE);
      chk("drain_not_halted", 32'(halted), 32'd0);
      cyc();
      chk("halted", 32'(halted), 32'd1);
      chk("halted_wr", 32'(wr_en), 32'd0);
      halt_req = 1;
      cyc();
      halt_req = 0;
      chk("halted_wb_ready", 32'(wb_ready), 32'd0);
      chk("halted_stays", 32'(halted), 32'd1);
      rst = 1; wb_valid = 0;
      cyc();
      rst = 0;

      // reset during drain
      halt_req = 1; mdu_busy = 1;
      cyc();
      halt_req = 0; mdu_valid = 1; mdu_addr = 3; rst = 1;
      #1 chk("rst_drain_mdu_ready", 32'(mdu_ready), 32'd0);
      cyc();
      rst = 0; mdu_valid = 0; mdu_busy = 0;
      chk("rst_drain_wr", 32'(wr_en), 32'd0);
      chk("rst_drain_halted", 32'(halted), 32'd0);
      wb_valid = 1; wb_addr = 4;
      #1 chk("rst_drain_run", 32'(wb_ready), 32'd1);
      cyc();
      wb_valid = 0;

      // idle halt
      halt_req = 1;
      cyc();
      halt_req = 0; wb_valid = 1; wb_addr = 6;
      #1 chk("idle_drain_halted", 32'(halted), 32'd0);
      chk("idle_drain_wb", 32'(wb_ready), 32'd0);
      cyc();
      chk("idle_halted", 32'(halted), 32'd1);
      chk("idle_halted_wb", 32'(wb_ready), 32'd0);
      cyc();
      chk("idle_halted_wb2", 32'(wb_ready), 32'd0);
      rst = 1;
      cyc();
      rst = 0; wb_valid = 0;

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         wb_hold  = wb_valid && !wb_ready && !rst;
         mdu_hold = mdu_valid && !mdu_ready && !rst;
         cyc();
         rst = ($urandom_range(0, 99) == 0);
         halt_req = ($urandom_range(0, 39) == 0);
         mdu_busy = ($urandom_range(0, 2) == 0);
         if (!wb_hold) begin
            wb_valid = ($urandom_range(0, 2) != 0);
            wb_addr  = 5'($urandom);
            wb_data  = $urandom;
            wb_mode  = 2'($urandom_range(0, 2));
         end
         if (!mdu_hold) begin
            mdu_valid = $urandom_range(0, 1) == 1;
            mdu_addr  = 5'($urandom);
            mdu_data  = $urandom;
            mdu_mode  = 2'($urandom_range(0, 2));
         end
      end
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regwr_arb.md
REGWR_ARB -- requirements
Module: regwr_arb

Interface
REQ-001 Parameters: WIDTH 32 = register data width; REG_ADDR_LEN 5 = register address width; STARVE_LIMIT 3 = consecutive MDU stall cycles before MDU gets priority (legal range 1..7).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 wb_valid  in  1  pipeline write-back request valid.
REQ-005 wb_ready  out  1  pipeline request accepted this cycle.
REQ-006 wb_addr / wb_data / wb_mode  in  REG_ADDR_LEN / WIDTH / 2  pipeline destination, value, w_mode (0 word, 1 halfword, 2 byte).
REQ-007 mdu_valid  in  1  multi-cycle unit (mul/div) write request valid.
REQ-008 mdu_ready  out  1  MDU request accepted this cycle.
REQ-009 mdu_addr / mdu_data / mdu_mode  in  REG_ADDR_LEN / WIDTH / 2  MDU destination, value, w_mode.
REQ-010 mdu_busy  in  1  MDU has an operation in flight that will later raise mdu_valid.
REQ-011 halt_req  in  1  halt request from write-back stage (single-cycle pulse).
REQ-012 halted  out  1  processor halted, all writes drained.
REQ-013 Addr / Data / wr_en / w_mode  out  REG_ADDR_LEN / WIDTH / 1 / 2  register-file write port, all registered.

Function
REQ-014 Transfer occurs on a requester when valid and ready are both 1 in the same cycle; at most one transfer per cycle.
REQ-015 Requester holds addr/data/mode stable while valid=1 and ready=0; the arbiter never drops a request without a transfer.
REQ-016 ready outputs are combinational from current state, starve_cnt and valid inputs; no dependence of valid on ready.
REQ-017 Default priority: WB over MDU; if both valid, wb_ready=1, mdu_ready=0.
REQ-018 starve_cnt (3 bits): +1 each cycle mdu_valid=1 and mdu_ready=0, saturating at STARVE_LIMIT; cleared on MDU transfer.
REQ-019 When starve_cnt == STARVE_LIMIT and mdu_valid=1, MDU has priority over WB for that cycle.
REQ-020 Write latency: transfer in cycle N -> Addr/Data/w_mode = transferred values and wr_en=1 in cycle N+1; no transfer in N -> wr_en=0 in N+1, Addr/Data/w_mode hold previous values.
REQ-021 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-022 RUN: arbitration per REQ-017..019; halt_req=1 -> DRAIN next cycle; a WB transfer in the same cycle as halt_req completes normally.
REQ-023 DRAIN: wb_ready=0; MDU served whenever mdu_valid=1; -> HALTED when mdu_valid=0 and mdu_busy=0 (may be the first DRAIN cycle).
REQ-024 HALTED: wb_ready=0, mdu_ready=0, halted=1, wr_en=0 after the final drained write retires; exit only via rst; halt_req ignored.
REQ-025 halt_req in DRAIN is ignored.

Reset
REQ-026 rst=1 at posedge: state=RUN, starve_cnt=0, wr_en=0, Addr=0, Data=0, w_mode=0, halted=0.
REQ-027 rst mid-operation (any state, pending requests) aborts without a write; wr_en=0 the following cycle; no transfer is reported in a cycle with rst=1 (both ready=0 while rst=1).

Configuration
REQ-028 Macro REGWR_ZERO_REG_EN: when defined, a transfer with addr==0 completes the handshake but wr_en stays 0 in N+1 (register 0 hard-wired); when undefined, address 0 is written like any other.

Verification
REQ-029 WB only: wb_valid=1, addr=5, data=0x1234, mode=0 in cycle N -> wb_ready=1 in N; Addr=5, Data=0x1234, wr_en=1 in N+1; wr_en=0 in N+2 if no further request.
REQ-030 Contention: wb_valid and mdu_valid held 1 continuously, STARVE_LIMIT=3 -> WB wins 3 cycles, MDU transfers in 4th cycle, starve_cnt=0 after, pattern repeats.
REQ-031 Halt drain: halt_req pulse with mdu_busy=1, then mdu_valid=1 (addr=7, data=0xCAFE) 4 cycles later -> wb_ready=0 from next cycle, MDU write of reg 7 occurs, halted=1 in the cycle after mdu_valid and mdu_busy are both 0.
REQ-032 halt_req with mdu_busy=0, mdu_valid=0 -> DRAIN one cycle, halted=1 two cycles after pulse; further wb_valid never accepted.
REQ-033 rst asserted in DRAIN with mdu_valid=1 -> mdu_ready=0, no write, state RUN, halted=0 next cycle.
REQ-034 With REGWR_ZERO_REG_EN: wb transfer addr=0, data=0xFFFF -> wb_ready=1, wr_en=0 in N+1; without macro -> wr_en=1, Addr=0.
